// File: rtl/gen_argmax_if.sv
// Sample-in / result-out handshake bundle for gen_argmax.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface gen_argmax_if #(
    parameter int DATA_W  = 16,
    parameter int N_CLASS = 4
);
    localparam int IDX_W = $clog2(N_CLASS);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_value;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_value
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_index,
        output out_value
    );
endinterface

// File: rtl/gen_argmax.sv
// Streaming argmax over fixed-length frames of N_CLASS activations, with one-hot LED latch.
// Define GEN_ARGMAX_SIGNED_EN for two's-complement comparison; unsigned otherwise.
module gen_argmax #(
    parameter int DATA_W  = 16,
    parameter int N_CLASS = 4
) (
    input  logic               clk,
    input  logic               rst,
    gen_argmax_if.slave        bus,
    output logic [N_CLASS-1:0] led,
    output logic               err_len
);
    localparam int IDX_W = $clog2(N_CLASS);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_CLASS - 1);

    typedef enum logic {StScan, StHold} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   best_val_q, best_val_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic [DATA_W-1:0]   out_value_q, out_value_d;
    logic [IDX_W-1:0]    out_index_q, out_index_d;
    logic [N_CLASS-1:0]  led_q, led_d;
    logic                err_len_q, err_len_d;

    logic                xfer;
    logic                at_last;
    logic                greater;
    logic                take;
    logic [DATA_W-1:0]   cand_val;
    logic [IDX_W-1:0]    cand_idx;

`ifdef GEN_ARGMAX_SIGNED_EN
    assign greater = $signed(bus.in_data) > $signed(best_val_q);
`else
    assign greater = bus.in_data > best_val_q;
`endif

    assign bus.in_ready = (state_q == StScan);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign at_last      = (cnt_q == LAST_CNT);

    // First sample of a frame always seeds the best; ties keep the earlier index.
    assign take     = (cnt_q == '0) || greater;
    assign cand_val = take ? bus.in_data : best_val_q;
    assign cand_idx = take ? cnt_q : best_idx_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        out_value_d = out_value_q;
        out_index_d = out_index_q;
        led_d       = led_q;
        err_len_d   = err_len_q;

        unique case (state_q)
            StScan: begin
                if (xfer) begin
                    best_val_d = cand_val;
                    best_idx_d = cand_idx;
                    // Frame length is counted; in_last is only cross-checked.
                    if (bus.in_last != at_last) begin
                        err_len_d = 1'b1;
                    end
                    if (at_last) begin
                        cnt_d       = '0;
                        out_value_d = cand_val;
                        out_index_d = cand_idx;
                        led_d       = N_CLASS'(1) << cand_idx;
                        state_d     = StHold;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StScan;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StScan;
            cnt_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            out_value_q <= '0;
            out_index_q <= '0;
            led_q       <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
            led_q       <= led_d;
            err_len_q   <= err_len_d;
        end
    end

    assign bus.out_valid = (state_q == StHold);
    assign bus.out_index = out_index_q;
    assign bus.out_value = out_value_q;
    assign led           = led_q;
    assign err_len       = err_len_q;

endmodule

// File: doc/gen_argmax.md
# gen_argmax

- Parametrised output-layer decision block for the neural-network datapath.
- Accepts a frame of `N_CLASS` output activations, one per cycle over a valid/ready stream, and tracks the running maximum.
- Presents the winning class index and value through an output handshake, and latches a one-hot LED vector of the last decision.
- Generalises the two-output comparator/LED stage to N classes with handshaking and frame checking.

## Interface
Parameters:
- `DATA_W`, 16, width of each activation sample.
- `N_CLASS`, 4, number of samples per frame; legal range 2..256.
- `IDX_W`, `$clog2(N_CLASS)`, localparam (derived, not overridable); width of the class index.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: sample valid.
- `in_ready`, output, 1: block can accept a sample.
- `in_data`, input, `DATA_W`: activation sample.
- `in_last`, input, 1: marks the final sample of a frame.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_index`, output, `IDX_W`: winning class index.
- `out_value`, output, `DATA_W`: winning activation.
- `led`, output, `N_CLASS`: one-hot display of the last decision.
- `err_len`, output, 1: sticky frame-length error flag.

## Operation
- Two states: SCAN and HOLD. Reset enters SCAN with `cnt=0`.
- A sample transfers when `in_valid && in_ready`.
- `in_ready` = 1 in SCAN and 0 in HOLD (combinational from state only).
- SCAN behaviour:
  - The sample at `cnt=0` loads `best_val`/`best_idx` unconditionally.
  - Later samples replace the best only if strictly greater. Ties keep the lower index.
  - `cnt` increments on every transfer.
- Transfer at `cnt==N_CLASS-1`:
  - Result registers take the final best, including this sample.
  - `led` is loaded with the one-hot of the winning index.
  - `cnt` returns to 0 and the state goes to HOLD.
- HOLD behaviour:
  - `out_valid`=1, and `out_index`/`out_value` stay stable.
  - On `out_ready`=1, the state returns to SCAN.
- Frame length is fixed by `cnt`, not by `in_last`.
  - `err_len` sets if `in_last`=1 on a transfer with `cnt!=N_CLASS-1`.
  - `err_len` also sets if `in_last`=0 on the transfer at `cnt==N_CLASS-1`.
  - The frame continues unaffected in both cases.
- `err_len` clears only on `rst`.
- `led` holds the last decision across later frames until the next frame completes.
- Reset values: `out_valid`=0, `out_index`=0, `out_value`=0, `led`=0 (no LED lit), `err_len`=0, `in_ready`=1 once `rst` deasserts.
- Reset mid-frame or during HOLD discards the partial frame and the pending result immediately (asynchronous).

## Timing
- `out_valid` rises on the cycle after the transfer at `cnt==N_CLASS-1`. `led` updates on the same edge.
- Minimum frame period is `N_CLASS`+1 cycles when `out_ready` is tied high: N transfer cycles plus one HOLD cycle.
- No sample is accepted in the HOLD cycle where `out_ready` is sampled high. The next frame may start on the following cycle.
- `in_valid` low stalls the scan with no state change; `cnt` and `best` are held.
- `in_data` is don't-care when `in_valid`=0. Upstream must hold `in_data`/`in_last` while `in_valid && !in_ready`.
- All outputs except `in_ready` are registered.

## Configuration
- `GEN_ARGMAX_SIGNED_EN` defined: `in_data` and `best_val` are compared as two's-complement signed values (Q-format activations).
- Not defined: comparison is unsigned.
- Ports and timing are identical in both builds.

## Test plan
- Unsigned build, `N_CLASS`=4, frame 0x0010,0x0300,0x0200,0x0100 with `in_last` on the 4th sample:
  - `out_valid` 1 cycle later, `out_index`=1, `out_value`=0x0300, `led`=4'b0010, `err_len`=0.
- Tie: frame 0x0050,0x0050,0x0010,0x0050 → `out_index`=0, `led`=4'b0001.
- Sign handling, frame 0x8000,0x0001,0x0000,0x0002:
  - Unsigned build: `out_index`=0.
  - `GEN_ARGMAX_SIGNED_EN` build: `out_index`=3, `out_value`=0x0002.
- Backpressure: hold `out_ready`=0 for 5 cycles after a frame:
  - `out_valid` stays 1, outputs stable, `in_ready`=0 throughout.
  - Release `out_ready`; the next frame is accepted on the following cycle. `led` keeps its old value until that frame completes.
- Length error: `in_last` asserted on the 2nd sample → `err_len`=1 and stays 1. The frame still completes after the 4th sample with a correct argmax.
- Assert `rst` after 2 samples of a frame:
  - Outputs return to reset values asynchronously.
  - The following full frame 0x0001,0x0002,0x0003,0x0004 gives `out_index`=3, with no carry-over from the aborted frame.
